// File: rtl/qspi_arb_pkg.sv
// QSPI0 flash arbiter shared types.
// State encoding and parked-pad levels.
package qspi_arb_pkg;

   typedef enum logic [2:0] {
      ST_SOC,
      ST_HOLD,
      ST_TURN_IN,
      ST_LOADER,
      ST_TURN_OUT,
      ST_RELEASE
   } arb_state_e;

   localparam logic       PARK_CS  = 1'b1;
   localparam logic       PARK_SCK = 1'b0;
   localparam logic [3:0] PARK_OE  = 4'h0;
   localparam logic [3:0] PARK_DQ  = 4'h0;

   function automatic logic is_park(arb_state_e s);
      return (s == ST_TURN_IN) || (s == ST_TURN_OUT);
   endfunction

endpackage

// File: rtl/qspi_pad_mux.sv
// Registered 2:1 QSPI pad mux with park override.
// Reset parks the pads asynchronously.
module qspi_pad_mux
   import qspi_arb_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       sel_ld_i,
   input  logic       park_i,
   input  logic       a_sck_i,
   input  logic       a_cs_i,
   input  logic [3:0] a_dq_i,
   input  logic [3:0] a_oe_i,
   input  logic       b_sck_i,
   input  logic       b_cs_i,
   input  logic [3:0] b_dq_i,
   input  logic [3:0] b_oe_i,
   output logic       pad_sck_o,
   output logic       pad_cs_o,
   output logic [3:0] pad_dq_o,
   output logic [3:0] pad_oe_o
);

   logic       sck_d, sck_q;
   logic       cs_d,  cs_q;
   logic [3:0] dq_d,  dq_q;
   logic [3:0] oe_d,  oe_q;

   // Pick park, loader (b) or SoC (a) for the next pad value.
   always_comb begin
      sck_d = a_sck_i;
      cs_d  = a_cs_i;
      dq_d  = a_dq_i;
      oe_d  = a_oe_i;
      if (park_i) begin
         sck_d = PARK_SCK;
         cs_d  = PARK_CS;
         dq_d  = PARK_DQ;
         oe_d  = PARK_OE;
      end else if (sel_ld_i) begin
         sck_d = b_sck_i;
         cs_d  = b_cs_i;
         dq_d  = b_dq_i;
         oe_d  = b_oe_i;
      end
   end

   // One register stage on every pad so skew is uniform.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sck_q <= PARK_SCK;
         cs_q  <= PARK_CS;
         dq_q  <= PARK_DQ;
         oe_q  <= PARK_OE;
      end else begin
         sck_q <= sck_d;
         cs_q  <= cs_d;
         dq_q  <= dq_d;
         oe_q  <= oe_d;
      end
   end

   assign pad_sck_o = sck_q;
   assign pad_cs_o  = cs_q;
   assign pad_dq_o  = dq_q;
   assign pad_oe_o  = oe_q;

endmodule

// File: rtl/qspi0_flash_arbiter.sv
// QSPI0 flash port arbiter: SoC controller vs FPGA loader.
// Quiet-wait, turnaround gap and loader hold watchdog.
module qspi0_flash_arbiter
   import qspi_arb_pkg::*;
#(
   parameter int unsigned QUIET_CYC = 8,
   parameter int unsigned TURN_CYC  = 4,
   parameter int unsigned HOLD_MAX  = 1048575
) (
   input  logic       clk_16M,
   input  logic       reset_periph,
   input  logic       soc_sck,
   input  logic       soc_cs,
   input  logic [3:0] soc_dq_o,
   input  logic [3:0] soc_dq_oe,
   input  logic       ld_req,
   output logic       ld_gnt,
   input  logic       ld_sck,
   input  logic       ld_cs,
   input  logic [3:0] ld_dq_o,
   input  logic [3:0] ld_dq_oe,
   output logic [3:0] dq_i,
   output logic       soc_hold,
   output logic       timeout,
   output logic       pad_sck,
   output logic       pad_cs,
   output logic [3:0] pad_dq_o,
   output logic [3:0] pad_dq_oe,
   input  logic [3:0] pad_dq_i
);

   localparam int QW = $clog2(QUIET_CYC + 1);
   localparam logic [QW-1:0] QUIET_N = QW'(QUIET_CYC);
   localparam logic [7:0]    TURN_N  = 8'(TURN_CYC);
   localparam logic [19:0]   HOLD_N  = 20'(HOLD_MAX);

   arb_state_e    state_d, state_q;
   logic [QW-1:0] quiet_d, quiet_q, quiet_inc;
   logic [7:0]    turn_d,  turn_q,  turn_inc;
   logic [19:0]   wd_d,    wd_q,    wd_inc;
   logic          timeout_d, timeout_q;
   logic          block_d,   block_q;

   assign quiet_inc = quiet_q + 1'b1;
   assign turn_inc  = turn_q + 8'd1;
   assign wd_inc    = wd_q + 20'd1;

   // Next state, counters and re-grant block.
   always_comb begin
      state_d   = state_q;
      quiet_d   = '0;
      turn_d    = '0;
      wd_d      = '0;
      timeout_d = timeout_q;
      block_d   = block_q;
      if (!ld_req) block_d = 1'b0;
      unique case (state_q)
         ST_SOC: begin
            if (ld_req && !block_q) state_d = ST_HOLD;
         end
         ST_HOLD: begin
            if (!ld_req) begin
               state_d = ST_RELEASE;
            end else if (soc_cs) begin
               if (quiet_inc == QUIET_N) state_d = ST_TURN_IN;
               else quiet_d = quiet_inc;
            end
         end
         ST_TURN_IN: begin
            if (turn_inc == TURN_N) state_d = ST_LOADER;
            else turn_d = turn_inc;
         end
         ST_LOADER: begin
            if (!ld_req) begin
               state_d = ST_TURN_OUT;
            end else if (ld_cs) begin
               if (wd_inc == HOLD_N) begin
                  state_d   = ST_TURN_OUT;
                  timeout_d = 1'b1;
                  block_d   = 1'b1;
               end else begin
                  wd_d = wd_inc;
               end
            end
         end
         ST_TURN_OUT: begin
            if (turn_inc == TURN_N) state_d = ST_RELEASE;
            else turn_d = turn_inc;
         end
         ST_RELEASE: state_d = ST_SOC;
         default:    state_d = ST_SOC;
      endcase
   end

   // State and counter registers.
   always_ff @(posedge clk_16M or posedge reset_periph) begin
      if (reset_periph) begin
         state_q   <= ST_SOC;
         quiet_q   <= '0;
         turn_q    <= '0;
         wd_q      <= '0;
         timeout_q <= 1'b0;
         block_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         quiet_q   <= quiet_d;
         turn_q    <= turn_d;
         wd_q      <= wd_d;
         timeout_q <= timeout_d;
         block_q   <= block_d;
      end
   end

   assign ld_gnt   = (state_q == ST_LOADER);
   assign soc_hold = (state_q == ST_HOLD)    ||
                     (state_q == ST_TURN_IN) ||
                     (state_q == ST_LOADER)  ||
                     (state_q == ST_TURN_OUT);
   assign timeout  = timeout_q;
   assign dq_i     = pad_dq_i;

   // Mux keys off the next state so pads change with ownership.
   qspi_pad_mux u_mux (
      .clk_i     (clk_16M),
      .rst_i     (reset_periph),
      .sel_ld_i  (state_d == ST_LOADER),
      .park_i    (is_park(state_d)),
      .a_sck_i   (soc_sck),
      .a_cs_i    (soc_cs),
      .a_dq_i    (soc_dq_o),
      .a_oe_i    (soc_dq_oe),
      .b_sck_i   (ld_sck),
      .b_cs_i    (ld_cs),
      .b_dq_i    (ld_dq_o),
      .b_oe_i    (ld_dq_oe),
      .pad_sck_o (pad_sck),
      .pad_cs_o  (pad_cs),
      .pad_dq_o  (pad_dq_o),
      .pad_oe_o  (pad_dq_oe)
   );

endmodule
